// File: rtl/tlb_lru_tracker.sv
// True-LRU age tracker for the set-associative TLB.
// Promotes accessed ways to MRU and answers registered victim queries.
module tlb_lru_tracker #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 16,
  parameter int WAY_BITS = $clog2(NUM_WAYS),
  parameter int SET_BITS = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  output logic                busy,
  input  logic                upd_valid,
  input  logic [SET_BITS-1:0] upd_set,
  input  logic [WAY_BITS-1:0] upd_way,
  input  logic                vq_valid,
  input  logic [SET_BITS-1:0] vq_set,
  input  logic [NUM_WAYS-1:0] vq_valid_mask,
  input  logic [NUM_WAYS-1:0] vq_lock_mask,
  output logic                vr_valid,
  output logic [WAY_BITS-1:0] vr_way,
  output logic                vr_none
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [SET_BITS-1:0] LAST = SET_BITS'(NUM_SETS - 1);

  state_t              state, state_nxt;
  logic [SET_BITS-1:0] cnt, cnt_nxt;

  logic [WAY_BITS-1:0] age [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0] upd_row [NUM_WAYS];
  logic [WAY_BITS-1:0] new_row [NUM_WAYS];
  logic [WAY_BITS-1:0] q_row [NUM_WAYS];
  logic [WAY_BITS-1:0] acc_age;
  logic [WAY_BITS-1:0] best;
  logic [WAY_BITS-1:0] pick_way;
  logic [NUM_WAYS-1:0] cand, inv;
  logic                pick_none, found;
  logic                run, upd_en, vq_en, bypass;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      INIT: begin
        if (flush) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy   = (state == INIT);
  assign run    = (state == RUN) && !flush && !rst;
  assign upd_en = run && upd_valid;
  assign vq_en  = run && vq_valid;
  assign bypass = upd_en && (upd_set == vq_set);

  // Promotion: ways younger than the accessed one age by one.
  always_comb begin
    acc_age = age[upd_set][upd_way];
    for (int w = 0; w < NUM_WAYS; w++) begin
      upd_row[w] = age[upd_set][w];
      if (WAY_BITS'(w) == upd_way)
        new_row[w] = '0;
      else if (upd_row[w] < acc_age)
        new_row[w] = upd_row[w] + 1'b1;
      else
        new_row[w] = upd_row[w];
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++)
      q_row[w] = bypass ? new_row[w] : age[vq_set][w];
  end

  // Invalid unlocked ways win; otherwise the oldest unlocked way.
  always_comb begin
    cand      = ~vq_lock_mask;
    inv       = cand & ~vq_valid_mask;
    pick_none = (cand == '0);
    pick_way  = '0;
    best      = '0;
    found     = 1'b0;
    if (inv != '0) begin
      for (int w = NUM_WAYS - 1; w >= 0; w--)
        if (inv[w]) pick_way = WAY_BITS'(w);
    end else begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (cand[w] && (!found || q_row[w] > best)) begin
          found    = 1'b1;
          best     = q_row[w];
          pick_way = WAY_BITS'(w);
        end
      end
    end
  end

  // Ages need no reset: the init sweep rewrites every set.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int w = 0; w < NUM_WAYS; w++)
        age[cnt][w] <= WAY_BITS'(w);
    end else if (upd_en) begin
      for (int w = 0; w < NUM_WAYS; w++)
        age[upd_set][w] <= new_row[w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vr_valid <= 1'b0;
      vr_way   <= '0;
      vr_none  <= 1'b0;
    end else begin
      vr_valid <= vq_en;
      if (vq_en) begin
        vr_way  <= pick_way;
        vr_none <= pick_none;
      end
    end
  end

endmodule

// File: tb/tb_tlb_lru_tracker.sv
// Bench for tlb_lru_tracker: directed steps plus random traffic
// checked against a recency-list model of each set.
module tb_tlb_lru_tracker;

  logic       clk = 1'b0;
  logic       rst, flush, busy;
  logic       upd_valid, vq_valid;
  logic [3:0] upd_set, vq_set;
  logic [1:0] upd_way, vr_way;
  logic [3:0] vq_valid_mask, vq_lock_mask;
  logic       vr_valid, vr_none;

  int tests = 0;
  int fails = 0;

  // ord[s][0] is the most recently used way, last entry the LRU.
  int ord [16][$];

  tlb_lru_tracker #(.NUM_WAYS(4), .NUM_SETS(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy),
    .upd_valid(upd_valid), .upd_set(upd_set), .upd_way(upd_way),
    .vq_valid(vq_valid), .vq_set(vq_set),
    .vq_valid_mask(vq_valid_mask), .vq_lock_mask(vq_lock_mask),
    .vr_valid(vr_valid), .vr_way(vr_way), .vr_none(vr_none)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; upd_valid = 0; vq_valid = 0;
    upd_set = 0; upd_way = 0; vq_set = 0;
    vq_valid_mask = 4'hF; vq_lock_mask = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      ord[s].delete();
      for (int w = 0; w < 4; w++) ord[s].push_back(w);
    end
  endfunction

  function automatic void model_upd(int s, int w);
    for (int i = 0; i < ord[s].size(); i++)
      if (ord[s][i] == w) begin
        ord[s].delete(i);
        break;
      end
    ord[s].push_front(w);
  endfunction

  function automatic void model_pick(int s, logic [3:0] v, logic [3:0] l,
                                     output int way, output bit none);
    way = 0; none = 1;
    for (int w = 0; w < 4; w++)
      if (!l[w] && !v[w]) begin
        way = w; none = 0;
        return;
      end
    for (int i = 3; i >= 0; i--)
      if (!l[ord[s][i]]) begin
        way = ord[s][i]; none = 0;
        return;
      end
  endfunction

  task automatic expect_resp(string tag, int s, logic [3:0] v, logic [3:0] l);
    int  w;
    bit  n;
    model_pick(s, v, l, w, n);
    check({tag, "_vld"}, vr_valid, 1);
    check({tag, "_way"}, vr_way, w);
    check({tag, "_none"}, vr_none, n);
  endtask

  task automatic do_query(string tag, int s, logic [3:0] v, logic [3:0] l);
    vq_valid = 1; vq_set = 4'(s);
    vq_valid_mask = v; vq_lock_mask = l;
    step();
    idle();
    expect_resp(tag, s, v, l);
  endtask

  task automatic do_upd(int s, int w);
    upd_valid = 1; upd_set = 4'(s); upd_way = 2'(w);
    step();
    idle();
    model_upd(s, w);
  endtask

  task automatic count_busy(output int n, input int reflush_at);
    n = 0;
    while (busy && n < 100) begin
      flush = (n == reflush_at);
      upd_valid = 1'($urandom_range(0, 1));
      upd_set = 4'($urandom); upd_way = 2'($urandom);
      vq_valid = 1; vq_set = 4'($urandom);
      n++;
      step();
      check("sweep_noresp", vr_valid, 0);
    end
    idle();
  endtask

  initial begin
    int  n;
    int  fixed_way;
    bit  uv, qv;
    int  us, uw, qs;
    logic [3:0] vm, lm;

    idle();
    rst = 1;
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_vr_valid", vr_valid, 0);
    check("rst_vr_way", vr_way, 0);
    check("rst_vr_none", vr_none, 0);
    rst = 0;
    count_busy(n, -1);
    check("rst_busy_len", n, 16);
    model_reset();

    do_query("init_q3", 3, 4'hF, 4'h0);
    check("init_q3_const", vr_way, 3);
    step();
    check("vr_one_cycle", vr_valid, 0);
    check("vr_way_hold", vr_way, 3);

    do_upd(5, 3); do_upd(5, 2); do_upd(5, 1); do_upd(5, 0);
    do_query("lru5", 5, 4'hF, 4'h0);
    check("lru5_const", vr_way, 3);
    do_upd(5, 3);
    do_query("lru5b", 5, 4'hF, 4'h0);
    check("lru5b_const", vr_way, 2);

    do_query("inv7", 7, 4'b1011, 4'h0);
    check("inv7_const", vr_way, 2);
    do_query("inv7_lk", 7, 4'b0011, 4'b0100);
    check("inv7_lk_const", vr_way, 3);

    do_query("lock_all", 7, 4'hF, 4'hF);
    check("lock_all_none", vr_none, 1);
    check("lock_all_way", vr_way, 0);
    do_query("lock_lru", 7, 4'hF, 4'b1000);
    check("lock_lru_const", vr_way, 2);

    upd_valid = 1; upd_set = 0; upd_way = 3;
    vq_valid = 1; vq_set = 0;
    step();
    idle();
    model_upd(0, 3);
    expect_resp("bypass", 0, 4'hF, 4'h0);
    check("bypass_const", vr_way, 2);

    for (int i = 0; i < 400; i++) begin
      uv = 1'($urandom_range(0, 1));
      qv = 1'($urandom_range(0, 1));
      us = $urandom_range(0, 15);
      uw = $urandom_range(0, 3);
      qs = ($urandom_range(0, 3) == 0) ? us : $urandom_range(0, 15);
      vm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      lm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      upd_valid = uv; upd_set = 4'(us); upd_way = 2'(uw);
      vq_valid = qv; vq_set = 4'(qs);
      vq_valid_mask = vm; vq_lock_mask = lm;
      step();
      if (uv) model_upd(us, uw);
      if (qv) expect_resp("rand", qs, vm, lm);
      else check("rand_idle", vr_valid, 0);
    end
    idle();

    for (int s = 0; s < 16; s++) do_upd(s, $urandom_range(0, 3));
    flush = 1;
    step();
    flush = 0;
    count_busy(n, -1);
    check("flush_busy_len", n, 16);
    model_reset();
    for (int s = 0; s < 16; s++) begin
      fixed_way = 3;
      do_query("flush_set", s, 4'hF, 4'h0);
      check("flush_set_const", vr_way, fixed_way);
    end

    do_upd(2, 3);
    flush = 1;
    step();
    flush = 0;
    count_busy(n, 7);
    check("reflush_busy_len", n, 24);
    model_reset();
    do_query("reflush_q2", 2, 4'hF, 4'h0);

    vq_valid = 1; vq_set = 1; flush = 1;
    step();
    idle();
    check("flush_q_drop", vr_valid, 0);
    check("flush_q_busy", busy, 1);
    count_busy(n, -1);
    check("flush_q_len", n, 16);

    vq_valid = 1; vq_set = 4; rst = 1;
    step();
    rst = 0;
    idle();
    check("rst_q_drop", vr_valid, 0);
    check("rst_q_busy", busy, 1);
    count_busy(n, -1);
    check("rst_q_len", n, 16);
    model_reset();
    do_query("post_rst", 4, 4'hF, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
